// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared types and arithmetic helpers for the RS/OS processing
//               element (state encoding, saturating add, product scaling).
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MAC       = 2'd1,
        WAIT_PSUM = 2'd2,
        OUT       = 2'd3
    } pe_state_e;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w);
        return sat_clip(a + b, w);
    endfunction

    // Fixed-point rescale of the full-precision product; caller narrows it.
    function automatic logic signed [63:0] scale_trunc(input logic signed [63:0] prod,
                                                       input int shift);
        return prod >>> shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_spad.sv
`default_nettype none
// ============================================================================
// Module      : pe_spad
// Description : DATA_W x TAPS shift-register scratchpad; newest entry at [0],
//               with an indexed read port and a dedicated head output.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_spad #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 3,
    parameter int IDX_W  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic        [IDX_W-1:0]  idx_i,
    output logic signed [DATA_W-1:0] rd_o,
    output logic signed [DATA_W-1:0] head_o
);

    logic signed [DATA_W-1:0] r_mem [TAPS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < TAPS; k++)
                r_mem[k] <= '0;
        end else if (wr_i) begin
            r_mem[0] <= din_i;
            for (int k = 1; k < TAPS; k++)
                r_mem[k] <= r_mem[k-1];
        end
    end

    assign rd_o   = r_mem[idx_i];
    assign head_o = r_mem[0];

endmodule
`default_nettype wire

// File: rtl/pe_rs_os_param.sv
`default_nettype none
// ============================================================================
// Module      : pe_rs_os_param
// Description : Parametrised row-stationary / output-stationary PE with psum
//               valid/ready handshakes. Define PE_SAT_EN for saturating math.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_rs_os_param
    import pe_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PSUM_W     = 10,
    parameter int TAPS       = 3,
    parameter int FRAC_SHIFT = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [DATA_W-1:0] filter_i,
    input  logic                     filter_wr_i,
    input  logic signed [DATA_W-1:0] ifmap_i,
    input  logic                     ifmap_wr_i,
    input  logic                     mode_i,
    input  logic                     start_i,
    input  logic                     mac_en_i,
    input  logic                     end_os_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    input  logic                     psum_valid_i,
    output logic                     psum_ready_o,
    output logic signed [PSUM_W-1:0] psum_o,
    output logic                     psum_valid_o,
    input  logic                     psum_ready_i,
    output logic signed [DATA_W-1:0] filter_o,
    output logic signed [DATA_W-1:0] ifmap_o,
    output logic                     busy_o
);

    localparam int               CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TAPS - 1);

    pe_state_e                r_state;
    pe_state_e                w_state_nxt;
    logic        [CNT_W-1:0]  r_cnt;
    logic        [CNT_W-1:0]  w_rd_idx;
    logic signed [PSUM_W-1:0] r_acc;
    logic signed [PSUM_W-1:0] r_psum;
    logic                     r_psum_valid;
    logic signed [DATA_W-1:0] r_filter_fwd;
    logic signed [DATA_W-1:0] r_ifmap_fwd;
    logic signed [DATA_W-1:0] w_f_rd;
    logic signed [DATA_W-1:0] w_i_rd;
    logic signed [DATA_W-1:0] w_f_head;
    logic signed [DATA_W-1:0] w_i_head;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [63:0]       w_scaled;
    logic signed [PSUM_W-1:0] w_term;
    logic signed [PSUM_W-1:0] w_acc_term;
    logic signed [PSUM_W-1:0] w_acc_psum;

    // One shared multiplier: OS always uses tap 0, RS walks the taps.
    assign w_rd_idx = (r_state == MAC) ? r_cnt : '0;

    pe_spad #(.DATA_W(DATA_W), .TAPS(TAPS), .IDX_W(CNT_W)) u_filter_spad (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wr_i  (filter_wr_i),
        .din_i (filter_i),
        .idx_i (w_rd_idx),
        .rd_o  (w_f_rd),
        .head_o(w_f_head)
    );

    pe_spad #(.DATA_W(DATA_W), .TAPS(TAPS), .IDX_W(CNT_W)) u_ifmap_spad (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wr_i  (ifmap_wr_i),
        .din_i (ifmap_i),
        .idx_i (w_rd_idx),
        .rd_o  (w_i_rd),
        .head_o(w_i_head)
    );

    assign w_prod   = w_f_rd * w_i_rd;
    assign w_scaled = scale_trunc(64'(w_prod), FRAC_SHIFT);

`ifdef PE_SAT_EN
    assign w_term     = PSUM_W'(sat_clip(w_scaled, PSUM_W));
    assign w_acc_term = PSUM_W'(sat_add(64'(r_acc), 64'(w_term), PSUM_W));
    assign w_acc_psum = PSUM_W'(sat_add(64'(r_acc), 64'(psum_i), PSUM_W));
`else
    assign w_term     = PSUM_W'(w_scaled);
    assign w_acc_term = r_acc + w_term;
    assign w_acc_psum = r_acc + psum_i;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mode_i) begin
                    if (start_i)
                        w_state_nxt = MAC;
                end else if (end_os_i) begin
                    w_state_nxt = OUT;
                end
            end
            MAC:       if (r_cnt == C_LAST) w_state_nxt = WAIT_PSUM;
            WAIT_PSUM: if (psum_valid_i)    w_state_nxt = OUT;
            OUT:       if (psum_ready_i)    w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
            r_filter_fwd <= '0;
            r_ifmap_fwd  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_filter_fwd <= w_f_head;
            r_ifmap_fwd  <= w_i_head;
            case (r_state)
                IDLE: begin
                    if (mode_i) begin
                        if (start_i) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
                    end else if (end_os_i) begin
                        r_psum       <= mac_en_i ? w_acc_term : r_acc;
                        r_psum_valid <= 1'b1;
                        r_acc        <= '0;
                    end else if (mac_en_i) begin
                        r_acc <= w_acc_term;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_term;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                WAIT_PSUM: begin
                    if (psum_valid_i) begin
                        r_psum       <= w_acc_psum;
                        r_psum_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (psum_ready_i)
                        r_psum_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign psum_ready_o = (r_state == WAIT_PSUM);
    assign busy_o       = (r_state != IDLE);
    assign psum_o       = r_psum;
    assign psum_valid_o = r_psum_valid;
    assign filter_o     = r_filter_fwd;
    assign ifmap_o      = r_ifmap_fwd;

endmodule
`default_nettype wire

// File: tb/tb_pe_rs_os_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_rs_os_param
// Description : Randomised scoreboard bench for pe_rs_os_param against an
//               arithmetic reference model of RS and OS dataflows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_rs_os_param;

    localparam int DATA_W     = 8;
    localparam int PSUM_W     = 10;
    localparam int TAPS       = 3;
    localparam int FRAC_SHIFT = 6;
    localparam int PMAX       = (1 << (PSUM_W - 1)) - 1;
    localparam int PMIN       = -(1 << (PSUM_W - 1));

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic signed [DATA_W-1:0] filter_i;
    logic                     filter_wr_i;
    logic signed [DATA_W-1:0] ifmap_i;
    logic                     ifmap_wr_i;
    logic                     mode_i;
    logic                     start_i;
    logic                     mac_en_i;
    logic                     end_os_i;
    logic signed [PSUM_W-1:0] psum_i;
    logic                     psum_valid_i;
    logic                     psum_ready_o;
    logic signed [PSUM_W-1:0] psum_o;
    logic                     psum_valid_o;
    logic                     psum_ready_i;
    logic signed [DATA_W-1:0] filter_o;
    logic signed [DATA_W-1:0] ifmap_o;
    logic                     busy_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Reference model state: scratchpads (index 0 = newest) and accumulator.
    int m_f[TAPS];
    int m_i[TAPS];
    int m_acc;
    int new_f[TAPS];
    int new_i[TAPS];

    pe_rs_os_param #(
        .DATA_W(DATA_W), .PSUM_W(PSUM_W), .TAPS(TAPS), .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .filter_i(filter_i), .filter_wr_i(filter_wr_i),
        .ifmap_i(ifmap_i), .ifmap_wr_i(ifmap_wr_i),
        .mode_i(mode_i), .start_i(start_i), .mac_en_i(mac_en_i), .end_os_i(end_os_i),
        .psum_i(psum_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
        .psum_o(psum_o), .psum_valid_o(psum_valid_o), .psum_ready_i(psum_ready_i),
        .filter_o(filter_o), .ifmap_o(ifmap_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int fix(input int x);
`ifdef PE_SAT_EN
        if (x > PMAX) return PMAX;
        if (x < PMIN) return PMIN;
        return x;
`else
        int m;
        m = x & ((1 << PSUM_W) - 1);
        if (m > PMAX) m = m - (1 << PSUM_W);
        return m;
`endif
    endfunction

    function automatic int term(input int f, input int i);
        return fix((f * i) >>> FRAC_SHIFT);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every accepted output beat is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && psum_valid_o && psum_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_psum", int'(psum_o), 0);
            end else begin
                check("psum_o", int'(psum_o), exp_q.pop_front());
            end
        end
    end

    task automatic write_spads();
        for (int j = TAPS - 1; j >= 0; j--) begin
            filter_wr_i = 1'b1;
            ifmap_wr_i  = 1'b1;
            filter_i    = DATA_W'(new_f[j]);
            ifmap_i     = DATA_W'(new_i[j]);
            step();
            for (int k = TAPS - 1; k > 0; k--) begin
                m_f[k] = m_f[k-1];
                m_i[k] = m_i[k-1];
            end
            m_f[0] = new_f[j];
            m_i[0] = new_i[j];
        end
        filter_wr_i = 1'b0;
        ifmap_wr_i  = 1'b0;
        step();
        check("filter_o", int'(filter_o), m_f[0]);
        check("ifmap_o", int'(ifmap_o), m_i[0]);
    endtask

    task automatic run_rs(input int ps, input int dly);
        int n;
        int exp;
        mode_i  = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n = 0;
        while (!psum_ready_o && n < 50) begin
            step();
            n++;
        end
        check("rs_cycles_to_wait", n, TAPS);
        check("rs_busy", int'(busy_o), 1);
        repeat (dly) step();
        check("rs_ready_held", int'(psum_ready_o), 1);
        m_acc = 0;
        for (int k = 0; k < TAPS; k++)
            m_acc = fix(m_acc + term(m_f[k], m_i[k]));
        exp = fix(m_acc + ps);
        exp_q.push_back(exp);
        psum_valid_i = 1'b1;
        psum_i       = PSUM_W'(ps);
        step();
        psum_valid_i = 1'b0;
        check("rs_valid_latency", int'(psum_valid_o), 1);
        step();
        check("rs_back_to_idle", int'(busy_o), 0);
    endtask

    // OS: mac pattern bits (LSB first) over ncyc cycles, then end_os with mac_last.
    task automatic run_os(input int ncyc, input int pattern, input bit mac_last,
                          input bit backpressure);
        int exp;
        int held;
        mode_i = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            mac_en_i = pattern[c];
            if (pattern[c]) m_acc = fix(m_acc + term(m_f[0], m_i[0]));
            step();
        end
        mac_en_i = mac_last;
        end_os_i = 1'b1;
        exp = mac_last ? fix(m_acc + term(m_f[0], m_i[0])) : m_acc;
        m_acc = 0;
        exp_q.push_back(exp);
        if (backpressure) psum_ready_i = 1'b0;
        step();
        mac_en_i = 1'b0;
        end_os_i = 1'b0;
        check("os_valid", int'(psum_valid_o), 1);
        if (backpressure) begin
            held = int'(psum_o);
            mode_i  = 1'b1;
            start_i = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step();
                check("bp_psum_stable", int'(psum_o), held);
                check("bp_valid_held", int'(psum_valid_o), 1);
                check("bp_busy", int'(busy_o), 1);
            end
            start_i      = 1'b0;
            mode_i       = 1'b0;
            psum_ready_i = 1'b1;
        end
        step();
        check("os_back_to_idle", int'(busy_o), 0);
        check("os_valid_dropped", int'(psum_valid_o), 0);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        filter_i = '0; filter_wr_i = 1'b0; ifmap_i = '0; ifmap_wr_i = 1'b0;
        mode_i = 1'b0; start_i = 1'b0; mac_en_i = 1'b0; end_os_i = 1'b0;
        psum_i = '0; psum_valid_i = 1'b0; psum_ready_i = 1'b1;
        m_acc = 0;
        for (int k = 0; k < TAPS; k++) begin m_f[k] = 0; m_i[k] = 0; end
        step(); step();
        check("rst_psum_o", int'(psum_o), 0);
        check("rst_psum_valid_o", int'(psum_valid_o), 0);
        check("rst_psum_ready_o", int'(psum_ready_o), 0);
        check("rst_busy_o", int'(busy_o), 0);
        check("rst_filter_o", int'(filter_o), 0);
        check("rst_ifmap_o", int'(ifmap_o), 0);
        rst_i = 1'b0;
        step();

        // RS basic: terms 3,2,1 plus psum 4
        new_f = '{64, 64, 64}; new_i = '{3, 2, 1};
        write_spads();
        run_rs(4, 1);
        // RS saturation / wrap
        new_f = '{127, 127, 127}; new_i = '{127, 127, 127};
        write_spads();
        run_rs(0, 0);
        // RS negative
        new_f = '{-128, -128, -128}; new_i = '{127, 127, 127};
        write_spads();
        run_rs(-5, 2);
        // OS: 64*64 for five cycles, then end without mac
        new_f = '{64, 0, 0}; new_i = '{64, 0, 0};
        write_spads();
        m_acc = 0;
        mode_i = 1'b0; end_os_i = 1'b1; exp_q.push_back(m_acc_flush());
        step(); end_os_i = 1'b0; step();
        run_os(5, 5'b11111, 1'b0, 1'b0);
        // Backpressure in OUT with start_i held high
        run_os(2, 2'b01, 1'b1, 1'b1);

        // Randomised RS and OS transactions
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < TAPS; k++) begin
                new_f[k] = int'($signed(DATA_W'($urandom)));
                new_i[k] = int'($signed(DATA_W'($urandom)));
            end
            write_spads();
            run_rs(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 3)));
            run_os(int'($urandom_range(1, 8)), int'($urandom), 1'($urandom), 1'b0);
        end

        // Reset during MAC cycle 1: abort without emitting
        mode_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        check("midrst_psum_o", int'(psum_o), 0);
        check("midrst_valid", int'(psum_valid_o), 0);
        check("midrst_ready", int'(psum_ready_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_filter_o", int'(filter_o), 0);
        m_acc = 0;
        for (int k = 0; k < TAPS; k++) begin m_f[k] = 0; m_i[k] = 0; end
        rst_i = 1'b0;
        repeat (4) begin
            step();
            check("midrst_no_valid", int'(psum_valid_o), 0);
        end
        run_rs(77, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin step(); n++; end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Flushes the stale accumulator (left by the last RS run) via end_os.
    function automatic int m_acc_flush();
        int v;
        v = 0;
        for (int k = 0; k < TAPS; k++)
            v = fix(v + term(-128, 127));
        return v;
    endfunction

endmodule
`default_nettype wire
